// File: rtl/fetch_byte_seq_if.sv
// Request / memory / instruction signal bundle for the byte-serial fetch sequencer.
// The slave modport is the sequencer; master is the fetch, ROM and consumer side.
interface fetch_byte_seq_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                     req;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     req_ready;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [7:0]               mem_byte;
  logic [DATA_WIDTH-1:0]    instr;
  logic                     instr_valid;
  logic                     instr_ready;
  logic                     misaligned;
  logic                     flush;

  modport master (
    output req, req_addr, mem_byte, instr_ready, flush,
    input  req_ready, mem_addr, instr, instr_valid, misaligned
  );

  modport slave (
    input  req, req_addr, mem_byte, instr_ready, flush,
    output req_ready, mem_addr, instr, instr_valid, misaligned
  );
endinterface

// File: rtl/fetch_byte_seq.sv
// Fetches four consecutive bytes from a combinational byte ROM, one per cycle,
// and presents them as one little-endian instruction with valid/ready handshake.
module fetch_byte_seq #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst,
  fetch_byte_seq_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [ADDRESS_WIDTH-1:0] maddr_q, maddr_d;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic                     valid_q, valid_d;
  logic                     mis_q, mis_d;
  logic                     accept;

  assign cur_addr      = base_q + ADDRESS_WIDTH'(idx_q);
  assign bus.req_ready = !bus.flush &&
                         (state_q == IDLE || (state_q == HOLD && bus.instr_ready));
  assign accept        = bus.req && bus.req_ready;

  // Outside READ the address output parks on the last byte actually read.
  assign bus.mem_addr    = (state_q == READ) ? cur_addr : maddr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.misaligned  = mis_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    maddr_d = maddr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;

    if (state_q == READ) maddr_d = cur_addr;

    if (bus.flush) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      valid_d = 1'b0;
    end else if (accept) begin
      // Covers both a fresh request in IDLE and a refill on the HOLD handshake.
      state_d = READ;
      idx_d   = 2'd0;
      base_d  = bus.req_addr;
      mis_d   = (bus.req_addr[1:0] != 2'b00);
      valid_d = 1'b0;
    end else begin
      case (state_q)
        READ: begin
          case (idx_q)
            2'd0:    instr_d[7:0]   = bus.mem_byte;
            2'd1:    instr_d[15:8]  = bus.mem_byte;
            2'd2:    instr_d[23:16] = bus.mem_byte;
            default: instr_d[31:24] = bus.mem_byte;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      base_q  <= '0;
      maddr_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      maddr_q <= maddr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end
endmodule
